// File: rtl/fs_serial_ctrl.sv
// Bit-serial subtractor: operands are shifted LSB-first through one fs_1bit cell,
// one bit per clock, and the difference and flags are returned over a valid/ready handshake.

module fs_1bit (
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic d_o,
  output logic bout_o
);
  assign d_o    = a_i ^ b_i ^ bin_i;
  assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);
endmodule

// state | meaning
// IDLE  | waiting for an operand pair, in_ready=1
// RUN   | one operand bit per clock through the cell, WIDTH cycles
// DONE  | result presented, held until out_ready
module fs_serial_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             ovf,
  output logic             busy
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d, res_q, res_d;
  logic             borrow_q, borrow_d;
  logic             a_msb_q, a_msb_d, b_msb_q, b_msb_d;
  logic             cell_d, cell_bout;

  fs_1bit u_cell (
    .a_i    (sa_q[0]),
    .b_i    (sb_q[0]),
    .bin_i  (borrow_q),
    .d_o    (cell_d),
    .bout_o (cell_bout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      sa_q     <= '0;
      sb_q     <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      res_q    <= res_d;
      borrow_q <= borrow_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    res_d    = res_q;
    borrow_d = borrow_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sa_d     = a;
          sb_d     = b;
          borrow_d = bin;
          a_msb_d  = a[WIDTH-1];
          b_msb_d  = b[WIDTH-1];
          cnt_d    = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        sa_d     = sa_q >> 1;
        sb_d     = sb_q >> 1;
        res_d    = {cell_d, res_q[WIDTH-1:1]};
        borrow_d = cell_bout;
        // Counter parks at 0 on the last bit so it never passes WIDTH-1.
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_RUN) || (state_q == S_DONE);
  assign diff      = out_valid ? res_q : '0;
  assign bout      = out_valid & borrow_q;
  assign zero      = out_valid & (res_q == '0);
  assign ovf       = out_valid & (a_msb_q != b_msb_q) & (res_q[WIDTH-1] != a_msb_q);

endmodule

// File: tb/tb_fs_serial_ctrl.sv
// Directed bench for fs_serial_ctrl (WIDTH=8): vector table plus backpressure,
// ignored-input, async-reset and back-to-back sequences.

module tb_fs_serial_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] diff;
  logic         bout, zero, ovf, busy;

  int checks = 0;
  int failures = 0;

  fs_serial_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout), .zero(zero), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] diff;
    logic       bout;
    logic       zero;
    logic       ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Accept one operand pair, return edges from accept to out_valid (result left in DONE).
  task automatic start_and_wait(input logic [7:0] av, input logic [7:0] bv, input logic bv_in,
                                output int lat);
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    a = av; b = bv; bin = bv_in; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    chk("busy_run", busy, 1);
    chk("diff_zero_in_run", diff, 0);
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      if (!out_valid) lat++;
      else break;
    end
    if (!out_valid) begin
      failures++;
      $display("FAIL timeout waiting out_valid actual=0 expected=1");
    end
  endtask

  int lat;
  int first_acc, gap, cyc;

  initial begin
    vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'h5A, 8'h5A, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0};

    #12 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_diff", diff, 0);
    chk("rst_flags", {bout, zero, ovf, busy}, 0);

    // Table-driven vectors, out_ready held high.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      start_and_wait(vecs[i].a, vecs[i].b, vecs[i].bin, lat);
      chk($sformatf("v%0d_latency", i), lat, 8);
      chk($sformatf("v%0d_diff", i), diff, vecs[i].diff);
      chk($sformatf("v%0d_bout", i), bout, vecs[i].bout);
      chk($sformatf("v%0d_zero", i), zero, vecs[i].zero);
      chk($sformatf("v%0d_ovf", i), ovf, vecs[i].ovf);
      @(posedge clk); #1;
      chk($sformatf("v%0d_drain", i), out_valid, 0);
      chk($sformatf("v%0d_diff_cleared", i), diff, 0);
    end

    // Backpressure: result held for 5 cycles in DONE.
    out_ready = 1'b0;
    start_and_wait(8'h80, 8'h01, 1'b0, lat);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_diff", diff, 8'h7F);
      chk("bp_flags", {bout, zero, ovf}, 3'b001);
      chk("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", out_valid, 0);

    // in_valid pulsed mid-RUN must be ignored.
    @(negedge clk);
    a = 8'h05; b = 8'h03; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    a = 8'hFF; b = 8'h00; bin = 1'b1; in_valid = 1'b1;
    chk("ign_in_ready", in_ready, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 40) begin @(posedge clk); #1; cyc++; end
    chk("ign_valid", out_valid, 1);
    chk("ign_diff", diff, 8'h02);
    chk("ign_bout", bout, 0);
    @(posedge clk); #1;

    // Async reset after 3 RUN cycles aborts the operation.
    @(negedge clk);
    a = 8'h5A; b = 8'h01; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_diff", diff, 0);
    chk("arst_flags", {bout, zero, ovf, busy}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("arst_no_pulse", out_valid, 0);
    end
    chk("arst_in_ready", in_ready, 1);
    start_and_wait(8'h10, 8'h01, 1'b0, lat);
    chk("arst_next_lat", lat, 8);
    chk("arst_next_diff", diff, 8'h0F);
    @(posedge clk); #1;

    // Back-to-back with in_valid held high: accept interval is WIDTH+2.
    @(negedge clk);
    a = 8'h05; b = 8'h03; bin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    first_acc = -1; gap = -1;
    for (int c = 0; c < 60 && gap < 0; c++) begin
      if (in_ready) begin
        if (first_acc < 0) first_acc = c;
        else gap = c - first_acc;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("issue_interval", gap, W + 2);
    repeat (12) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fs_serial_ctrl.md
Name: fs_serial_ctrl

Overview:
Bit-serial subtract controller for the ALU.
- Accepts a WIDTH-bit operand pair over a valid/ready handshake.
- Sequences the operands LSB-first through a single instance of the team's 1-bit full-subtractor cell (fs_1bit), one bit per clock.
- Returns the difference plus borrow, zero and signed-overflow flags over a valid/ready output handshake.
- Serves as the low-area subtract path for the pipeline's execute stage.

Parameters:
WIDTH, 8, operand/result width in bits (legal range 2..32)
CNT_W, $clog2(WIDTH)+1, bit counter width (derived; not to be overridden)

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  reset, asynchronous and active-low
in_valid  input  1  operand pair and bin are valid
in_ready  output  1  block can accept operands (IDLE only)
a  input  WIDTH  minuend
b  input  WIDTH  subtrahend
bin  input  1  borrow-in for multi-word subtraction
out_valid  output  1  result fields valid
out_ready  input  1  consumer accepts result
diff  output  WIDTH  a - b - bin, modulo 2^WIDTH
bout  output  1  final borrow-out (1 when a < b + bin, unsigned)
zero  output  1  diff == 0
ovf  output  1  signed overflow
busy  output  1  high in RUN or DONE

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - Counter, operand shift registers, result register and borrow register are cleared to 0.
  - Outputs: in_ready=1 after release, out_valid=0, diff=0, bout=0, zero=0, ovf=0, busy=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid&&in_ready: latch a→sa and b→sb, bin→borrow register, capture a[WIDTH-1] and b[WIDTH-1], clear counter to 0, go to RUN.
- RUN:
  - in_ready=0.
  - The subtractor cell is driven by A=sa[0], B=sb[0], Bin=borrow.
  - Each edge: shift sa and sb right by 1, shift Diff into the MSB of the result register (right shift), load Bout into the borrow register, increment the counter.
  - On the edge where the counter reaches WIDTH-1: go to DONE.
  - Exactly WIDTH RUN cycles.
- DONE:
  - out_valid=1.
  - diff = result register; bout = borrow register; zero = (diff==0); ovf = (a_msb != b_msb) && (diff[WIDTH-1] != a_msb).
  - All result outputs are held stable while out_ready=0.
  - On an edge with out_valid&&out_ready: go to IDLE; out_valid drops on the next cycle.
  - in_ready stays 0 in DONE; there is no same-cycle accept on result drain.
- Latency: out_valid rises WIDTH cycles after the accepting edge. Minimum issue interval is WIDTH+2 cycles.
- Output values outside DONE:
  - diff, bout, zero and ovf are driven to 0 whenever out_valid=0.
  - They are not a registered pass-through of stale values.
- bin applies to bit 0 only; flag equations hold with bin=1.
- in_valid while not IDLE is ignored. Operands are not queued and a/b are not resampled.
- out_ready while not DONE has no effect.
- Reset asserted mid-RUN or in DONE aborts the operation. No out_valid pulse is produced for the aborted operation.
- Counter never exceeds WIDTH-1; there is no wrap path.

Test Plan:
- WIDTH=8, a=0x05, b=0x03, bin=0, out_ready=1 → out_valid rises exactly 8 cycles after accept; diff=0x02, bout=0, zero=0, ovf=0.
- a=0x03, b=0x05 → diff=0xFE, bout=1, ovf=0. a=0x80, b=0x01 → diff=0x7F, bout=0, ovf=1.
- a=0x00, b=0x00, bin=1 → diff=0xFF, bout=1, zero=0. a=0x5A, b=0x5A, bin=0 → diff=0x00, zero=1, bout=0.
- Backpressure and ignored input:
  - Hold out_ready=0 for 5 cycles in DONE → diff, flags and out_valid stay constant; in_ready=0 throughout.
  - Pulse in_valid with a=0xFF mid-RUN → ignored; the current result is unchanged.
- Reset and back-to-back operation:
  - Assert rst_n=0 asynchronously after 3 RUN cycles → all outputs go to 0 immediately; after release in_ready=1; the next operation (0x10-0x01) yields diff=0x0F.
  - Back-to-back operations with out_ready=1 → accept interval is exactly WIDTH+2 cycles.
